// File: rtl/ex_muldiv_ctrl.sv
// RV32M multiply/divide unit for the Execute stage: a 32-iteration shift-add multiplier and
// restoring divider sharing one 64-bit accumulator, with stall/valid handshake to the pipeline.
module ex_muldiv_ctrl #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MulDivE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            StallMD,
  output logic            BusyMD,
  output logic            MDValidE,
  output logic [XLEN-1:0] MDResultE
);

  localparam int unsigned CntW = $clog2(ITER);
  localparam logic [CntW-1:0] LastCnt = CntW'(ITER - 1);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN - 1){1'b0}}};

  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Mulhu  = 3'b011;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Divu   = 3'b101;
  localparam logic [2:0] F3Rem    = 3'b110;
  localparam logic [2:0] F3Remu   = 3'b111;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic                neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand decode for a new op.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            is_div, div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    a_signed = (funct3E != F3Mulhu) && (funct3E != F3Divu) && (funct3E != F3Remu);
    b_signed = a_signed && (funct3E != F3Mulhsu);
    a_neg    = a_signed && SrcAE[XLEN-1];
    b_neg    = b_signed && SrcBE[XLEN-1];
    a_mag    = a_neg ? (-SrcAE) : SrcAE;
    b_mag    = b_neg ? (-SrcBE) : SrcBE;
    is_div   = funct3E[2];
    div_zero = is_div && (SrcBE == '0);
    // Only DIV and REM (funct3[0] == 0) can overflow.
    div_ovf  = is_div && !funct3E[0] && (SrcAE == MinNeg) && (SrcBE == '1);
    if (funct3E[1]) begin
      special_res = div_zero ? SrcAE : '0;
    end else begin
      special_res = div_zero ? '1 : MinNeg;
    end
  end

  // One iteration of each algorithm on the shared accumulator.
  // Multiply: {hi, lo} with multiplier in lo, shifted right each step.
  // Divide:   {rem, quot} with dividend in quot, shifted left each step.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_acc;
  logic [2*XLEN-1:0] step_acc;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {(XLEN + 1){1'b0}});
    mul_acc   = {mul_sum, acc_q[XLEN-1:1]};
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    if (div_trial[XLEN]) begin
      div_acc = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      div_acc = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
    step_acc = op_q[2] ? div_acc : mul_acc;
  end

  // Sign correction and result selection from the final iteration.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    prod = neg_q ? (-step_acc) : step_acc;
    quot = step_acc[XLEN-1:0];
    rem  = step_acc[2*XLEN-1:XLEN];
    case (op_q)
      F3Mul:                     final_res = prod[XLEN-1:0];
      F3Mulh, F3Mulhsu, F3Mulhu: final_res = prod[2*XLEN-1:XLEN];
      F3Div, F3Divu:             final_res = neg_q ? (-quot) : quot;
      F3Rem, F3Remu:             final_res = neg_rem_q ? (-rem) : rem;
      default:                   final_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    if (FlushE) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (MulDivE) begin
            op_d      = funct3E;
            a_d       = a_mag;
            b_d       = b_mag;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            count_d   = '0;
            acc_d     = is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            if (div_zero || div_ovf) begin
              result_d = special_res;
              state_d  = StDone;
            end else begin
              state_d  = StBusy;
            end
          end
        end
        StBusy: begin
          acc_d   = step_acc;
          count_d = count_q + 1'b1;
          if (count_q == LastCnt) begin
            result_d = final_res;
            state_d  = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    StallMD   = !FlushE && (((state_q == StIdle) && MulDivE) || (state_q == StBusy));
    BusyMD    = (state_q != StIdle);
    MDValidE  = (state_q == StDone) && !FlushE;
    MDResultE = result_q;
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: results, latency, stall window, specials, flush and reset.
module tb_ex_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MulDivE;
  logic [2:0]  funct3E;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        FlushE;
  logic        StallMD;
  logic        BusyMD;
  logic        MDValidE;
  logic [31:0] MDResultE;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv_ctrl #(.XLEN(32), .ITER(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .MulDivE   (MulDivE),
    .funct3E   (funct3E),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .FlushE    (FlushE),
    .StallMD   (StallMD),
    .BusyMD    (BusyMD),
    .MDValidE  (MDValidE),
    .MDResultE (MDResultE)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive one cycle's inputs at the falling edge, then let outputs settle.
  task automatic step(input logic mde, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic fl);
    @(negedge clk);
    MulDivE = mde;
    funct3E = f3;
    SrcAE   = a;
    SrcBE   = b;
    FlushE  = fl;
    #1;
  endtask

  // Issue one op (cycle T) and hold it until MDValidE; lat is cycles after T, -1 on timeout.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output int stall_n,
                       output logic busy_start, output logic stall_done);
    lat        = -1;
    res        = '0;
    stall_n    = 0;
    stall_done = 1'b1;
    step(1'b1, f3, a, b, 1'b0);
    busy_start = BusyMD;
    if (StallMD) stall_n++;
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, f3, a, b, 1'b0);
      if (MDValidE) begin
        lat        = i;
        res        = MDResultE;
        stall_done = StallMD;
        break;
      end
      if (StallMD) stall_n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; MulDivE = 1'b0; funct3E = '0; SrcAE = '0; SrcBE = '0; FlushE = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (StallMD !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", StallMD); end
    checks++; if (BusyMD !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BusyMD); end
    checks++; if (MDValidE !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", MDValidE); end
    checks++; if (MDResultE !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", MDResultE); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'(i), 32'h1234_5678, 32'h0, 1'b0);
      checks++; if ({StallMD, BusyMD, MDValidE} !== 3'b000) begin
        errors++; $display("FAIL idle_outputs: got %b want 000", {StallMD, BusyMD, MDValidE});
      end
    end
  endtask

  task automatic test_mul();
    logic [2:0]  f3 [4];
    logic [31:0] av [4];
    logic [31:0] bv [4];
    logic [31:0] ev [4];
    int          lat, stall_n;
    logic [31:0] res;
    logic        busy_start, stall_done;
    f3 = '{3'b000, 3'b001, 3'b010, 3'b011};
    av = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bv = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    ev = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    for (int i = 0; i < 4; i++) begin
      issue(f3[i], av[i], bv[i], lat, res, stall_n, busy_start, stall_done);
      checks++; if (res !== ev[i]) begin errors++; $display("FAIL mul_result[%0d]: got %h want %h", i, res, ev[i]); end
      checks++; if (lat != 33) begin errors++; $display("FAIL mul_latency[%0d]: got %0d want 33", i, lat); end
      checks++; if (stall_n != 33) begin errors++; $display("FAIL mul_stall_cycles[%0d]: got %0d want 33", i, stall_n); end
      checks++; if (stall_done !== 1'b0) begin errors++; $display("FAIL mul_stall_at_done[%0d]: got %b want 0", i, stall_done); end
    end
  endtask

  task automatic test_idle_hold();
    // Div-by-zero operands with MulDivE low must not start anything.
    step(1'b0, 3'b101, 32'h5, 32'h0, 1'b0);
    checks++; if ({StallMD, BusyMD, MDValidE} !== 3'b000) begin
      errors++; $display("FAIL hold_outputs: got %b want 000", {StallMD, BusyMD, MDValidE});
    end
    step(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    checks++; if (MDResultE !== 32'hFFFF_FFFE) begin errors++; $display("FAIL hold_result: got %h want fffffffe", MDResultE); end
  endtask

  task automatic test_div();
    logic [2:0]  f3 [4];
    logic [31:0] av [4];
    logic [31:0] bv [4];
    logic [31:0] ev [4];
    int          lat, stall_n;
    logic [31:0] res;
    logic        busy_start, stall_done;
    f3 = '{3'b100, 3'b110, 3'b101, 3'b111};
    av = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    bv = '{32'd2, 32'd2, 32'd7, 32'd7};
    ev = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      issue(f3[i], av[i], bv[i], lat, res, stall_n, busy_start, stall_done);
      checks++; if (res !== ev[i]) begin errors++; $display("FAIL div_result[%0d]: got %h want %h", i, res, ev[i]); end
      checks++; if (lat != 33) begin errors++; $display("FAIL div_latency[%0d]: got %0d want 33", i, lat); end
      checks++; if (stall_n != 33) begin errors++; $display("FAIL div_stall_cycles[%0d]: got %0d want 33", i, stall_n); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3 [5];
    logic [31:0] av [5];
    logic [31:0] bv [5];
    logic [31:0] ev [5];
    int          lat, stall_n;
    logic [31:0] res;
    logic        busy_start, stall_done;
    f3 = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b100};
    av = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5};
    bv = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    ev = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      issue(f3[i], av[i], bv[i], lat, res, stall_n, busy_start, stall_done);
      checks++; if (res !== ev[i]) begin errors++; $display("FAIL special_result[%0d]: got %h want %h", i, res, ev[i]); end
      checks++; if (lat != 1) begin errors++; $display("FAIL special_latency[%0d]: got %0d want 1", i, lat); end
      checks++; if (stall_n != 1) begin errors++; $display("FAIL special_stall_cycles[%0d]: got %0d want 1", i, stall_n); end
    end
  endtask

  task automatic test_flush();
    logic        saw_valid;
    int          lat, stall_n;
    logic [31:0] res;
    logic        busy_start, stall_done;
    saw_valid = 1'b0;
    step(1'b1, 3'b000, 32'd11, 32'd13, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 3'b000, 32'd11, 32'd13, 1'b0);
      saw_valid = saw_valid | MDValidE;
    end
    step(1'b1, 3'b000, 32'd11, 32'd13, 1'b1);
    checks++; if (StallMD !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", StallMD); end
    saw_valid = saw_valid | MDValidE;
    step(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    checks++; if (BusyMD !== 1'b0) begin errors++; $display("FAIL flush_idle: got busy %b want 0", BusyMD); end
    saw_valid = saw_valid | MDValidE;
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL flush_no_valid: got %b want 0", saw_valid); end
    issue(3'b101, 32'd9, 32'd3, lat, res, stall_n, busy_start, stall_done);
    checks++; if (res !== 32'd3) begin errors++; $display("FAIL flush_next_result: got %h want 3", res); end
    checks++; if (lat != 33) begin errors++; $display("FAIL flush_next_latency: got %0d want 33", lat); end
  endtask

  task automatic test_back_to_back();
    int          lat1, lat2, sn1, sn2;
    logic [31:0] r1, r2;
    logic        bs1, bs2, sd1, sd2;
    issue(3'b000, 32'd2, 32'd3, lat1, r1, sn1, bs1, sd1);
    issue(3'b000, 32'd4, 32'd5, lat2, r2, sn2, bs2, sd2);
    checks++; if (r1 !== 32'd6) begin errors++; $display("FAIL b2b_first_result: got %h want 6", r1); end
    checks++; if (lat1 != 33) begin errors++; $display("FAIL b2b_first_latency: got %0d want 33", lat1); end
    checks++; if (bs2 !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy %b want 0", bs2); end
    checks++; if (r2 !== 32'd20) begin errors++; $display("FAIL b2b_second_result: got %h want 14", r2); end
    checks++; if (lat2 != 33) begin errors++; $display("FAIL b2b_second_latency: got %0d want 33", lat2); end
  endtask

  task automatic test_reset_midop();
    step(1'b1, 3'b100, 32'd100, 32'd7, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b1, 3'b100, 32'd100, 32'd7, 1'b0);
    checks++; if (BusyMD !== 1'b1) begin errors++; $display("FAIL midop_busy: got %b want 1", BusyMD); end
    @(negedge clk);
    reset = 1'b1; MulDivE = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if ({StallMD, BusyMD, MDValidE} !== 3'b000) begin
      errors++; $display("FAIL midop_reset_ctrl: got %b want 000", {StallMD, BusyMD, MDValidE});
    end
    checks++; if (MDResultE !== 32'h0) begin errors++; $display("FAIL midop_reset_result: got %h want 0", MDResultE); end
    step(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    checks++; if (MDValidE !== 1'b0) begin errors++; $display("FAIL midop_no_valid: got %b want 0", MDValidE); end
  endtask

  initial begin
    reset = 1'b1; MulDivE = 1'b0; funct3E = '0; SrcAE = '0; SrcBE = '0; FlushE = 1'b0;
    test_reset();
    test_idle();
    test_mul();
    test_idle_hold();
    test_div();
    test_special();
    test_flush();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
